// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel encodings and the responder state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    SEND
  } rd_state_t;

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address and read data channels bundled for the responder.
interface axi_rd_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts plus legality of the burst shape.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_SIZE   = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] beats;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic                  wrap_len_ok;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    beats     = ADDR_WIDTH'(len) + ADDR_WIDTH'(1);
    wrap_mask = (beats << size) - ADDR_WIDTH'(1);
    incr_addr = addr + step;

    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_INCR:  next_addr = incr_addr;
      // Stay inside the aligned container, wrapping back to its base.
      AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:         next_addr = addr;
    endcase

    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    illegal     = (size > 3'(MAX_SIZE)) || (burst == 2'b11) ||
                  ((burst == AXI_BURST_WRAP) && !wrap_len_ok);
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave over an internal word array, with a backdoor preload port.
//   state  | meaning
//   IDLE   | arready high, waiting for an AR handshake
//   LOOKUP | one cycle: read the array for the current beat, set rresp/rlast
//   SEND   | rvalid high, beat held until rready
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  axi_rd_if.slave                      s_axi,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int STRB      = DATA_WIDTH / 8;
  localparam int LOG2_STRB = $clog2(STRB);
  localparam int IDX_W     = $clog2(MEM_WORDS);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  illegal;
  logic                  borrow;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_SIZE   (LOG2_STRB)
  ) u_burst_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .illegal   (illegal)
  );

  // Borrow out of the subtraction flags addresses below BASE_ADDR.
  always_comb begin
    {borrow, off} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    word_off      = off >> LOG2_STRB;
    in_range      = !borrow && (word_off < ADDR_WIDTH'(MEM_WORDS));
    idx           = word_off[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= AXI_RESP_OKAY;
      beat          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= AXI_BURST_FIXED;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.rid     <= s_axi.arid;
            addr_q        <= s_axi.araddr;
            len_q         <= s_axi.arlen;
            size_q        <= s_axi.arsize;
            burst_q       <= s_axi.arburst;
            beat          <= '0;
            s_axi.arready <= 1'b0;
            state         <= LOOKUP;
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        LOOKUP: begin
          s_axi.rlast <= (beat == len_q);
          if (illegal) begin
            s_axi.rresp <= AXI_RESP_SLVERR;
            s_axi.rdata <= '0;
          end else if (!in_range) begin
            s_axi.rresp <= AXI_RESP_DECERR;
            s_axi.rdata <= '0;
          end else begin
            s_axi.rresp <= AXI_RESP_OKAY;
            s_axi.rdata <= mem[idx];
          end
          s_axi.rvalid <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            if (s_axi.rlast) begin
              s_axi.rlast   <= 1'b0;
              s_axi.arready <= 1'b1;
              state         <= IDLE;
            end else begin
              beat   <= beat + 8'd1;
              addr_q <= next_addr;
              state  <= LOOKUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: WRAP/INCR/FIXED bursts, errors, stalls, reset and backdoor.
module tb_axi_rd_responder;
  import axi_pkg::*;

  localparam logic [63:0] PAT = 64'hA000_0000_0000_0000;

  logic        clk;
  logic        reset_n;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [63:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  axi_rd_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  axi_rd_responder #(
    .ID_WIDTH   (13),
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .MEM_WORDS  (4096),
    .BASE_ADDR  (64'h0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a negedge; returns on the negedge just after the AR handshake edge.
  task automatic issue_ar(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.arready !== 1'b1) begin $display("FAIL ar_timeout: arready=%b required 1", bus.arready); errors++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  // Waits for rvalid (rready assumed high), samples the beat and steps past its handshake.
  task automatic recv_beat(output logic [63:0] d, output logic [1:0] r, output logic [12:0] id,
                           output logic l);
    int n = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.rvalid !== 1'b1) begin $display("FAIL rvalid_timeout: rvalid=%b required 1", bus.rvalid); errors++; end
    d = bus.rdata; r = bus.rresp; id = bus.rid; l = bus.rlast;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.arready !== 1'b0) begin $display("FAIL reset_arready: got %b required 0", bus.arready); errors++; end
    checks++; if (bus.rvalid !== 1'b0) begin $display("FAIL reset_rvalid: got %b required 0", bus.rvalid); errors++; end
    checks++; if (bus.rlast !== 1'b0) begin $display("FAIL reset_rlast: got %b required 0", bus.rlast); errors++; end
    checks++; if (bus.rid !== 13'h0) begin $display("FAIL reset_rid: got %h required 0", bus.rid); errors++; end
    checks++; if (bus.rdata !== 64'h0) begin $display("FAIL reset_rdata: got %h required 0", bus.rdata); errors++; end
    checks++; if (bus.rresp !== 2'd0) begin $display("FAIL reset_rresp: got %0d required 0", bus.rresp); errors++; end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.arready !== 1'b1) begin $display("FAIL reset_arready_rise: got %b required 1", bus.arready); errors++; end
  endtask

  task automatic preload();
    for (int i = 0; i < 4096; i++) begin
      mem_we = 1'b1; mem_waddr = 12'(i); mem_wdata = PAT + 64'(i);
      @(negedge clk);
    end
    mem_we = 1'b0;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_idx [8] = '{12'h202, 12'h203, 12'h203, 12'h200, 12'h200, 12'h201, 12'h201, 12'h202};
    logic [63:0] d; logic [1:0] r; logic [12:0] id; logic l;
    issue_ar(13'h5, 64'h1014, 8'd7, 3'd2, AXI_BURST_WRAP);
    for (int b = 0; b < 8; b++) begin
      recv_beat(d, r, id, l);
      checks++; if (d !== PAT + 64'(exp_idx[b])) begin $display("FAIL wrap_data beat %0d: got %h required %h", b, d, PAT + 64'(exp_idx[b])); errors++; end
      checks++; if (r !== AXI_RESP_OKAY) begin $display("FAIL wrap_resp beat %0d: got %0d required 0", b, r); errors++; end
      checks++; if (id !== 13'h5) begin $display("FAIL wrap_id beat %0d: got %h required 5", b, id); errors++; end
      checks++; if (l !== (b == 7)) begin $display("FAIL wrap_last beat %0d: got %b required %b", b, l, (b == 7)); errors++; end
    end
  endtask

  task automatic test_incr_stall();
    logic [63:0] d0; logic [1:0] r0; logic [12:0] i0; logic l0;
    bus.rready = 1'b0;
    issue_ar(13'h11, 64'h0, 8'd3, 3'd3, AXI_BURST_INCR);
    checks++; if (bus.rvalid !== 1'b0) begin $display("FAIL incr_latency_early: rvalid=%b required 0", bus.rvalid); errors++; end
    @(negedge clk);
    checks++; if (bus.rvalid !== 1'b1) begin $display("FAIL incr_latency: rvalid=%b required 1", bus.rvalid); errors++; end
    for (int b = 0; b < 4; b++) begin
      int n = 0;
      while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
      checks++; if (bus.rvalid !== 1'b1) begin $display("FAIL incr_rvalid_timeout beat %0d: got %b required 1", b, bus.rvalid); errors++; end
      d0 = bus.rdata; r0 = bus.rresp; i0 = bus.rid; l0 = bus.rlast;
      checks++; if (d0 !== PAT + 64'(b)) begin $display("FAIL incr_data beat %0d: got %h required %h", b, d0, PAT + 64'(b)); errors++; end
      checks++; if (l0 !== (b == 3)) begin $display("FAIL incr_last beat %0d: got %b required %b", b, l0, (b == 3)); errors++; end
      checks++; if (i0 !== 13'h11) begin $display("FAIL incr_id beat %0d: got %h required 11", b, i0); errors++; end
      for (int s = 0; s < 2; s++) begin
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== d0 || bus.rlast !== l0 || bus.rid !== i0 || bus.rresp !== r0) begin
          $display("FAIL incr_stall_hold beat %0d: got v=%b d=%h l=%b required v=1 d=%h l=%b", b, bus.rvalid, bus.rdata, bus.rlast, d0, l0);
          errors++;
        end
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
    end
    bus.rready = 1'b1;
  endtask

  task automatic test_decerr();
    logic [63:0] d; logic [1:0] r; logic [12:0] id; logic l;
    issue_ar(13'h7, 64'h8000, 8'd0, 3'd3, AXI_BURST_INCR);
    recv_beat(d, r, id, l);
    checks++; if (r !== AXI_RESP_DECERR) begin $display("FAIL decerr_resp: got %0d required 3", r); errors++; end
    checks++; if (d !== 64'h0) begin $display("FAIL decerr_data: got %h required 0", d); errors++; end
    checks++; if (l !== 1'b1) begin $display("FAIL decerr_last: got %b required 1", l); errors++; end
    checks++; if (bus.arready !== 1'b1) begin $display("FAIL decerr_arready: got %b required 1", bus.arready); errors++; end
  endtask

  task automatic test_slverr();
    logic [63:0] d; logic [1:0] r; logic [12:0] id; logic l;
    issue_ar(13'h2, 64'h0, 8'd2, 3'd3, AXI_BURST_WRAP);
    for (int b = 0; b < 3; b++) begin
      recv_beat(d, r, id, l);
      checks++; if (r !== AXI_RESP_SLVERR) begin $display("FAIL slverr_resp beat %0d: got %0d required 2", b, r); errors++; end
      checks++; if (d !== 64'h0) begin $display("FAIL slverr_data beat %0d: got %h required 0", b, d); errors++; end
      checks++; if (l !== (b == 2)) begin $display("FAIL slverr_last beat %0d: got %b required %b", b, l, (b == 2)); errors++; end
    end
    checks++; if (bus.arready !== 1'b1) begin $display("FAIL slverr_arready: got %b required 1", bus.arready); errors++; end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d; logic [1:0] r; logic [12:0] id; logic l;
    int n = 0;
    issue_ar(13'h3, 64'h0, 8'd7, 3'd3, AXI_BURST_INCR);
    for (int b = 0; b < 2; b++) begin
      recv_beat(d, r, id, l);
      checks++; if (d !== PAT + 64'(b)) begin $display("FAIL rst_pre_data beat %0d: got %h required %h", b, d, PAT + 64'(b)); errors++; end
    end
    bus.rready = 1'b0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.rvalid !== 1'b1) begin $display("FAIL rst_beat3_timeout: rvalid=%b required 1", bus.rvalid); errors++; end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rvalid !== 1'b0) begin $display("FAIL rst_mid_rvalid: got %b required 0", bus.rvalid); errors++; end
    checks++; if (bus.rlast !== 1'b0) begin $display("FAIL rst_mid_rlast: got %b required 0", bus.rlast); errors++; end
    @(negedge clk);
    reset_n = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    checks++; if (bus.arready !== 1'b1) begin $display("FAIL rst_mid_arready: got %b required 1", bus.arready); errors++; end
    checks++; if (bus.rvalid !== 1'b0) begin $display("FAIL rst_mid_stray_rvalid: got %b required 0", bus.rvalid); errors++; end
    issue_ar(13'h9, 64'h28, 8'd0, 3'd3, AXI_BURST_INCR);
    recv_beat(d, r, id, l);
    checks++; if (d !== PAT + 64'h5) begin $display("FAIL rst_post_data: got %h required %h", d, PAT + 64'h5); errors++; end
    checks++; if (id !== 13'h9) begin $display("FAIL rst_post_id: got %h required 9", id); errors++; end
    checks++; if (r !== AXI_RESP_OKAY || l !== 1'b1) begin $display("FAIL rst_post_resp_last: got resp=%0d last=%b required 0/1", r, l); errors++; end
  endtask

  task automatic test_fixed_backdoor();
    logic [63:0] d; logic [1:0] r; logic [12:0] id; logic l;
    int n = 0;
    issue_ar(13'h4, 64'h10, 8'd3, 3'd3, AXI_BURST_FIXED);
    recv_beat(d, r, id, l);
    checks++; if (d !== PAT + 64'h2) begin $display("FAIL fixed_beat1: got %h required %h", d, PAT + 64'h2); errors++; end
    bus.rready = 1'b0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.rdata !== PAT + 64'h2) begin $display("FAIL fixed_beat2: got %h required %h", bus.rdata, PAT + 64'h2); errors++; end
    // Write while beat 2 is stalled in SEND, before beat 3's lookup.
    mem_we = 1'b1; mem_waddr = 12'h2; mem_wdata = 64'hDEAD;
    @(negedge clk);
    mem_we = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk);
    recv_beat(d, r, id, l);
    checks++; if (d !== 64'hDEAD) begin $display("FAIL fixed_beat3: got %h required dead", d); errors++; end
    // Now in beat 4's lookup cycle: a concurrent write must not be seen by this read.
    mem_we = 1'b1; mem_waddr = 12'h2; mem_wdata = 64'hBEEF;
    @(negedge clk);
    mem_we = 1'b0;
    recv_beat(d, r, id, l);
    checks++; if (d !== 64'hDEAD) begin $display("FAIL fixed_beat4_rbw: got %h required dead", d); errors++; end
    checks++; if (l !== 1'b1) begin $display("FAIL fixed_last: got %b required 1", l); errors++; end
    issue_ar(13'h4, 64'h10, 8'd0, 3'd3, AXI_BURST_FIXED);
    recv_beat(d, r, id, l);
    checks++; if (d !== 64'hBEEF) begin $display("FAIL fixed_after_write: got %h required beef", d); errors++; end
  endtask

  initial begin
    test_reset();
    preload();
    test_wrap();
    test_incr_stall();
    test_decerr();
    test_slverr();
    test_reset_mid_burst();
    test_fixed_backdoor();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel slave (AR/R) backed by an internal word-addressed memory array.
- Serves single or burst reads (FIXED/INCR/WRAP) issued by a fetch or load master.
- Serves as the memory-side model for bring-up and as the on-chip boot ROM/RAM read port.
- Backdoor write port lets the bench or loader preload contents.

Parameters:
- ID_WIDTH, 13, AXI ID width (matches bus)
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, R data width; STRB = DATA_WIDTH/8 bytes per word
- MEM_WORDS, 4096, array depth in DATA_WIDTH words
- BASE_ADDR, 64'h0, byte address of word 0

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_araddr  in  ADDR_WIDTH  start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
- s_axi_arvalid  in  1  request valid
- s_axi_arready  out  1  request accept
- s_axi_rid  out  ID_WIDTH  echoed arid
- s_axi_rdata  out  DATA_WIDTH  full aligned word containing the beat address
- s_axi_rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- s_axi_rlast  out  1  final beat
- s_axi_rvalid  out  1  beat valid
- s_axi_rready  in  1  master accept
- mem_we  in  1  backdoor write enable
- mem_waddr  in  $clog2(MEM_WORDS)  backdoor word index
- mem_wdata  in  DATA_WIDTH  backdoor data

Behaviour:
- Reset (async, reset_n low): state IDLE, arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, beat counter=0. Memory contents are not cleared. arready rises on the first clk edge after reset_n deasserts.
- One outstanding burst. arready=1 only in IDLE.
- States:
  - IDLE: on arvalid&arready, capture id, addr, len, size, burst. Clear arready. Go to LOOKUP.
  - LOOKUP: one cycle. Word index = (addr-BASE_ADDR)>>log2(STRB). Register mem[index] into rdata. Set rlast=(beat==len). Set rresp. Go to SEND.
  - SEND: rvalid=1. rid, rdata, rresp and rlast are held stable while rready=0. On rvalid&rready:
    - If rlast: rvalid=0, arready=1, go to IDLE.
    - Otherwise: beat+=1, addr=next_addr, go to LOOKUP.
- Latency: AR handshake in cycle N gives rvalid in cycle N+2. Sustained rate is one beat per 2 cycles with rready held high.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: container = (len+1)<<size; base = addr & ~(container-1); next = base | ((addr+(1<<size)) & (container-1)).
  - Arithmetic is ADDR_WIDTH bits; INCR wraps modulo 2^ADDR_WIDTH.
- Response rules (evaluated per beat in LOOKUP):
  - Address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*STRB): rresp=DECERR, rdata=0.
  - WRAP with len not in {1,3,7,15}, size>log2(STRB), or burst==3: SLVERR on every beat, rdata=0. Beat count still len+1.
  - Otherwise OKAY.
- Backdoor write in the same cycle as a LOOKUP read to the same index: the read returns the old data (read-before-write).
- reset_n asserted mid-burst: outputs clear immediately with no rlast. The burst is dropped.
- arvalid while busy is ignored until IDLE. AR fields are sampled only at handshake.

Decomposition:
- Package axi_pkg:
  - burst constants: AXI_BURST_FIXED/INCR/WRAP
  - response constants: AXI_RESP_OKAY/SLVERR/DECERR
  - rd_state_t enum: IDLE, LOOKUP, SEND
- Sub-module axi_burst_addr: combinational next-address and wrap-legality check. Inputs: addr, len, size, burst. Outputs: next_addr, illegal.

Test Plan:
- Preload mem[i]=64'hA000_0000_0000_0000+i. Request addr 0x1014, size 2, len 7, WRAP, id 0x5 -> 8 beats, word indices 0x202,0x203,0x203,0x200,0x200,0x201,0x201,0x202. All OKAY, rid=0x5, rlast only on beat 8.
- INCR addr 0x0, size 3, len 3, rready toggling 1,0,0,1 -> data A..00 through A..03 in order. Outputs stable during stall cycles. First rvalid 2 cycles after AR handshake.
- Request addr 0x8000 (beyond 4096 words), len 0 -> single beat, DECERR, rdata=0, rlast=1. arready returns to 1 next cycle.
- WRAP with len 2 -> 3 beats, all SLVERR, rlast on beat 3.
- Assert reset_n low during beat 3 of an 8-beat burst -> rvalid=0 immediately. After release arready=1, and a new request returns correct data.
- FIXED addr 0x10, len 3, with a backdoor write of mem[2]=0xDEAD between beats 2 and 3 -> beats 1-2 old value, beats 3-4 0xDEAD.
